hall_tachometer: RTL

HALL_TACHOMETER -- requirements
Module: hall_tachometer

---
 rtl/motor_pkg.sv | 50 +++++
 rtl/hall_tachometer_if.sv | 31 +++
 rtl/hall_debounce.sv | 60 ++++++
 rtl/hall_tachometer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : motor_pkg
//  Description : Shared motor-control constants: hall sector map, tachometer
//                FSM encoding, default widths and phase driver duty width.
//  Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

  // Default widths shared by the motor-control blocks
  localparam int c_default_debounce_cycles = 3;
  localparam int c_default_count_width     = 16;
  localparam int c_default_period_width    = 20;
  localparam int c_phase_duty_width        = 10;

  // Hall code for each commutation sector {hA,hB,hC}
  localparam logic [2:0] c_code_s0 = 3'b001;
  localparam logic [2:0] c_code_s1 = 3'b011;
  localparam logic [2:0] c_code_s2 = 3'b010;
  localparam logic [2:0] c_code_s3 = 3'b110;
  localparam logic [2:0] c_code_s4 = 3'b100;
  localparam logic [2:0] c_code_s5 = 3'b101;

  // Sector value returned for 000 / 111
  localparam logic [2:0] c_sector_invalid = 3'd7;

  // Tachometer FSM: ACQUIRE has no reference sector, TRACK holds one
  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } tach_state_t;

  // Translate a hall code into its sector number (0..5) or c_sector_invalid
  function automatic logic [2:0] hall_sector(input logic [2:0] code);
    logic [2:0] sector;
    sector = c_sector_invalid;
    case (code)
      c_code_s0: sector = 3'd0;
      c_code_s1: sector = 3'd1;
      c_code_s2: sector = 3'd2;
      c_code_s3: sector = 3'd3;
      c_code_s4: sector = 3'd4;
      c_code_s5: sector = 3'd5;
      default:   sector = c_sector_invalid;
    endcase
    return sector;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hall_tachometer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : hall_tachometer_if
//  Description : Hall input / tachometer result bundle. master drives the raw
//                hall lines and clear; slave is the tachometer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hall_tachometer_if #(
  parameter int COUNT_WIDTH  = 16,
  parameter int PERIOD_WIDTH = 20
);
  logic [2:0]                     h;
  logic                           clear;
  logic signed [COUNT_WIDTH-1:0]  position;
  logic [PERIOD_WIDTH-1:0]        period;
  logic                           direction;
  logic                           step;
  logic                           stalled;
  logic                           fault;

  modport master (
    output h, clear,
    input  position, period, direction, step, stalled, fault
  );

  modport slave (
    input  h, clear,
    output position, period, direction, step, stalled, fault
  );
endinterface
`default_nettype wire

// File: rtl/hall_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : hall_debounce
//  Description : 2-flop synchronizer for the raw hall lines followed by a
//                stability counter; emits a one-cycle accept strobe when a
//                new code has been stable for DEBOUNCE_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module hall_debounce
  import motor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles
) (
  input  wire logic       clock,
  input  wire logic       reset_n,
  input  wire logic [2:0] i_h,
  output logic      [2:0] o_code,
  output logic            o_accept
);

  localparam logic [3:0] c_target = 4'(DEBOUNCE_CYCLES);

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_prev;
  logic [3:0] r_cnt;
  logic [2:0] r_accepted;
  logic       r_accept;

  // Synchronize, count how long r_prev has been stable, accept new codes
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1    <= 3'b000;
      r_sync2    <= 3'b000;
      r_prev     <= 3'b000;
      r_cnt      <= 4'd0;
      r_accepted <= 3'b000;
      r_accept   <= 1'b0;
    end else begin
      r_sync1  <= i_h;
      r_sync2  <= r_sync1;
      r_prev   <= r_sync2;
      r_accept <= 1'b0;
      if (r_sync2 != r_prev) begin
        // the new value lands in r_prev this edge: its first stable cycle
        r_cnt <= 4'd1;
      end else if (r_cnt != c_target) begin
        r_cnt <= r_cnt + 4'd1;
      end else if (r_prev != r_accepted) begin
        r_accepted <= r_prev;
        r_accept   <= 1'b1;
      end
    end
  end

  assign o_code   = r_accepted;
  assign o_accept = r_accept;

endmodule
`default_nettype wire

// File: rtl/hall_tachometer.sv
`default_nettype none
// ============================================================================
//  Module      : hall_tachometer
//  Description : Hall-sensor tachometer: decodes debounced hall codes into
//                commutation steps, keeps a signed position count, measures
//                the step period and flags invalid codes / skipped sectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module hall_tachometer
  import motor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
  parameter int COUNT_WIDTH     = c_default_count_width,
  parameter int PERIOD_WIDTH    = c_default_period_width
) (
  input  wire logic         clock,
  input  wire logic         reset_n,
  hall_tachometer_if.slave  tach
);

  tach_state_t             r_state;
  tach_state_t             w_state_next;
  logic [2:0]              r_ref;
  logic [COUNT_WIDTH-1:0]  r_position;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic                    r_direction;
  logic                    r_step;
  logic                    r_fault;

  logic [2:0]              w_code;
  logic                    w_accept;
  logic [2:0]              w_sector;
  logic [3:0]              w_sum;
  logic [2:0]              w_delta;
  logic                    w_fwd;
  logic                    w_rev;
  logic                    w_fault_set;
  logic                    w_ref_load;
  logic [PERIOD_WIDTH-1:0] w_cnt_inc;

  hall_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_h      (tach.h),
    .o_code   (w_code),
    .o_accept (w_accept)
  );

  // Sector delta modulo 6 relative to the reference (both operands 0..5)
  assign w_sector  = hall_sector(w_code);
  assign w_sum     = {1'b0, w_sector} + 4'd6 - {1'b0, r_ref};
  assign w_delta   = (w_sum >= 4'd6) ? 3'(w_sum - 4'd6) : w_sum[2:0];
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ACQUIRE;
    else          r_state <= w_state_next;
  end

  // Next state and per-accept decisions
  always_comb begin
    w_state_next = r_state;
    w_fwd        = 1'b0;
    w_rev        = 1'b0;
    w_fault_set  = 1'b0;
    w_ref_load   = 1'b0;
    if (w_accept) begin
      if (w_sector == c_sector_invalid) begin
        w_fault_set  = 1'b1;
        w_state_next = ACQUIRE;
      end else begin
        w_ref_load = 1'b1;
        case (r_state)
          ACQUIRE: w_state_next = TRACK;
          TRACK: begin
            if (w_delta == 3'd1)      w_fwd       = 1'b1;
            else if (w_delta == 3'd5) w_rev       = 1'b1;
            else if (w_delta != 3'd0) w_fault_set = 1'b1;
          end
          default: w_state_next = ACQUIRE;
        endcase
      end
    end
  end

  // Position, direction, step strobe, fault, reference sector and period
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ref       <= 3'd0;
      r_position  <= '0;
      r_period    <= '0;
      r_cnt       <= '0;
      r_direction <= 1'b1;
      r_step      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_step <= w_fwd | w_rev;
      if (w_ref_load) r_ref <= w_sector;
      if (w_fwd) r_direction <= 1'b1;
      if (w_rev) r_direction <= 1'b0;

      // clear takes priority over a simultaneous step for the count
      if (tach.clear)  r_position <= '0;
      else if (w_fwd)  r_position <= r_position + 1'b1;
      else if (w_rev)  r_position <= r_position - 1'b1;

      if (tach.clear)       r_fault <= 1'b0;
      else if (w_fault_set) r_fault <= 1'b1;

      // counter runs only while tracking; a step latches it and restarts
      if (w_fwd || w_rev) begin
        r_period <= w_cnt_inc;
        r_cnt    <= '0;
      end else if (r_state == TRACK && w_state_next == TRACK) begin
        r_cnt <= w_cnt_inc;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign tach.position  = r_position;
  assign tach.period    = r_period;
  assign tach.direction = r_direction;
  assign tach.step      = r_step;
  assign tach.stalled   = &r_cnt;
  assign tach.fault     = r_fault;

endmodule
`default_nettype wire
